tick_divider_bank: RTL

//   Parametrised multi-channel clock/tick divider, successor to the single fixed divide-by constant.

---
 rtl/tick_divider_bank_pkg.sv | 22 ++
 rtl/tick_divider_bank_channel.sv | 72 +++++++
 rtl/tick_divider_bank.sv | 67 ++++++
 3 files changed

// File: rtl/tick_divider_bank_pkg.sv
// Shared constants and helpers for the tick divider bank and its channels.
package tick_divider_bank_pkg;

  // Default counter width and reset half-period for every divider channel.
  localparam int          CLK_CNT_W        = 28;
  localparam int unsigned CLK_DEFAULT_HALF = 65_000_000;

  // Half-periods the game code typically loads for blink and animation timing.
  localparam int unsigned CLK_BLINK_HALF   = 25_000_000;
  localparam int unsigned CLK_ANIM_HALF    = 6_500_000;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_divider_bank_channel.sv
// One divider channel: counts 0..half, emits a tick and toggles clk_out at
// each half-period boundary. A restart returns the phase to zero, and a write
// replaces the half-period.
module tick_divider_bank_channel
  import tick_divider_bank_pkg::*;
#(
  parameter int          CNT_W        = CLK_CNT_W,
  parameter int unsigned DEFAULT_HALF = CLK_DEFAULT_HALF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             at_terminal;

  // Treat any count at or beyond half as terminal so the counter can never run past it.
  assign at_terminal = (cnt_q >= half_q);

  // Next-state: restart beats terminal count, which beats increment; a write lands even during restart.
  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    if (wr) begin
      half_d = wr_half;
    end
    if (restart) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (en) begin
      if (at_terminal) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = ~clk_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset puts the channel at phase zero with the default half-period.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      half_q <= RESET_HALF;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Multi-channel tick/clock divider. Decodes run-time half-period loads,
// merges the global sync into every channel's restart, and acknowledges
// accepted loads one cycle later.
module tick_divider_bank
  import tick_divider_bank_pkg::*;
#(
  parameter int          CHANNELS     = 4,
  parameter int          CNT_W        = CLK_CNT_W,
  parameter int unsigned DEFAULT_HALF = CLK_DEFAULT_HALF,
  parameter int          CH_W         = clog2_min1(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [CNT_W-1:0]    load_half,
  output logic                load_ack,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out
);

  logic load_hit;
  logic load_ack_q, load_ack_d;

  // Loads aimed at a channel that does not exist are dropped silently.
  assign load_hit = load && (int'(load_ch) < CHANNELS);

  // Acknowledge exactly the loads that were accepted.
  always_comb begin
    load_ack_d = load_hit;
  end

  // Registered acknowledge so the output has no combinational path from inputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= load_ack_d;
    end
  end

  assign load_ack = load_ack_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic sel;

    assign sel = load_hit && (load_ch == CH_W'(gi));

    // A load also restarts its channel so a shrinking half-period cannot be overrun.
    tick_divider_bank_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_ch (
      .clk_in (clk_in),
      .reset  (reset),
      .en     (en[gi]),
      .restart(sync | sel),
      .wr     (sel),
      .wr_half(load_half),
      .tick   (tick[gi]),
      .clk_out(clk_out[gi])
    );
  end

endmodule
